if_fetch: RTL and testbench
===========================

Name: if_fetch

Overview:
- Instruction fetch unit: the producer side of the instruction/control interface consumed by `ctrl`.
- Issues word fetches to instruction memory over a valid/ready request channel.
- Buffers returned words with their PC and presents decoded fields (op, funct3, funct7) plus the full instruction to `ctrl` and the datapath.
- Consumes PCSrc/PCTarget from the execute side to redirect and flush.

Parameters:
XLEN, 32, address/data width
RESET_PC, 32'h0000_0000, first fetch address after reset
BUF_DEPTH, 2, instruction buffer entries; also the maximum number of outstanding requests

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  XLEN  word-aligned fetch address
imem_rsp_valid  in  1  response valid (in order, no backpressure)
imem_rsp_data  in  XLEN  fetched instruction word
PCSrc  in  1  redirect taken (branch/jump resolved)
PCTarget  in  XLEN  redirect address
dec_ready  in  1  downstream consumes instruction this cycle
instr_valid  out  1  buffer head valid
instr  out  XLEN  head instruction word
pc  out  XLEN  PC of head instruction
pc_plus4  out  XLEN  pc + 4
op  out  7  instr[6:0]
funct3  out  3  instr[14:12]
funct7  out  1  instr[30]

Behaviour:
- Reset (rst=1 on an edge):
  - fetch_pc <= RESET_PC; buffer emptied; outstanding <= 0; drop_cnt <= 0; state <= IDLE.
  - Outputs while in reset: imem_req_valid=0, instr_valid=0, instr/pc/op/funct3/funct7=0, pc_plus4=4.
  - Reset mid-transaction discards all in-flight responses. Memory is reset on the same rst, so no stale response arrives afterwards.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE: one cycle, then RUN.
  - RUN:
    - imem_req_valid=1 when outstanding + buffer occupancy < BUF_DEPTH.
    - Handshake completes on imem_req_valid & imem_req_ready; fetch_pc += 4 the same edge.
    - imem_req_addr is held stable while valid and not ready.
  - DRAIN: imem_req_valid=0. Each arriving response is discarded and drop_cnt is decremented. Go to RUN when drop_cnt reaches 0, or immediately if it was 0.
- Response path:
  - A response in RUN is pushed to the buffer with its PC, taken from an internal PC FIFO of issued addresses.
  - A response cannot overflow the buffer, by the credit rule above.
  - Minimum latency: request accepted in cycle N, response in N+1, instr_valid in N+2 (registered buffer).
- Head consumption: instr_valid & dec_ready pops the buffer head. op/funct3/funct7 are combinational slices of the head word.
- Redirect (PCSrc=1, sampled every cycle, any state):
  - Buffer flushed and fetch_pc <= PCTarget.
  - drop_cnt <= outstanding, excluding a response arriving the same cycle, which is itself dropped.
  - A request handshaking in the same cycle is counted as outstanding and dropped.
  - state <= DRAIN if the resulting drop_cnt > 0, else RUN.
  - instr_valid=0 the cycle after a redirect.
  - Redirect takes priority over push/pop in the same cycle.
  - PCTarget[1:0] is forced to 0.
- Back-to-back redirects: the latest one wins, and drop_cnt is recomputed from the current outstanding count.
- fetch_pc wraps modulo 2^XLEN (32'hFFFF_FFFC + 4 = 0).

Optional Feature:
- FETCH_PERF_EN:
  - Adds output ports perf_fetched[31:0] (responses accepted into the buffer) and perf_flushed[31:0] (buffer entries plus in-flight responses discarded by redirects).
  - Both counters are saturating and reset to 0.
- Without the macro: ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package riscy_pkg:
  - XLEN; opcode constants (OP_RTYPE 7'b0110011, OP_LOAD 7'b0000011, OP_STORE 7'b0100011, OP_BRANCH 7'b1100011, OP_JAL 7'b1101111, OP_ITYPE 7'b0010011).
  - Typedef fetch_state_e {IDLE, RUN, DRAIN}.
  - Typedef fetch_entry_t {pc, instr}.
- Sub-module fetch_fifo: parameterised BUF_DEPTH FIFO of fetch_entry_t with push, pop, flush, full, empty and count. Instanced for the instruction buffer and for the issued-PC queue.

Test Plan:
1. Reset release, memory always ready, 1-cycle latency, dec_ready=1 -> requests at 0x0, 0x4, 0x8; first instr_valid 2 cycles after first accept with pc=0, pc_plus4=4; op=7'b0000011 for word 32'h00002083 (lw).
2. dec_ready=0 for 6 cycles -> exactly BUF_DEPTH=2 requests issued, then imem_req_valid=0; after dec_ready=1, instructions appear in order with no loss or duplication.
3. Two requests outstanding, PCSrc=1 with PCTarget=0x100 -> state DRAIN, both late responses dropped, next request addr=0x100, first valid pc=0x100.
4. PCSrc=1 in the same cycle as a response and a request handshake -> both discarded, drop_cnt correct, no stale instruction ever reaches instr_valid.
5. imem_req_ready held 0 for 4 cycles -> imem_req_addr stable; rst asserted mid-wait -> next request addr=RESET_PC, instr_valid=0.
6. With FETCH_PERF_EN: 10 fetches, then a redirect flushing 2 buffered and 1 in-flight -> perf_fetched=10, perf_flushed=3.

Source files
------------

// File: rtl/riscy_pkg.sv
// Shared types and constants for the riscy fetch/control slice.
package riscy_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

endpackage

// File: rtl/if_fetch_if.sv
// Instruction-memory request/response channel between fetch (master) and memory (slave).
interface if_fetch_if;
  logic                        req_valid;
  logic                        req_ready;
  logic [riscy_pkg::XLEN-1:0]  req_addr;
  logic                        rsp_valid;
  logic [riscy_pkg::XLEN-1:0]  rsp_data;

  modport master (output req_valid, req_addr, input req_ready, rsp_valid, rsp_data);
  modport slave  (input req_valid, req_addr, output req_ready, rsp_valid, rsp_data);
endinterface

// File: rtl/if_fetch_fifo.sv
// Small synchronous FIFO of fetch entries with flush; used for the instruction buffer and issued-PC queue.
module fetch_fifo
  import riscy_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  fetch_entry_t  din,
  output fetch_entry_t  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign dout    = mem_q[rd_q];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_q] = din;
        wr_d        = ptr_inc(wr_q);
      end
      if (do_pop) rd_d = ptr_inc(rd_q);
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch unit: credit-limited word fetches, PC-tagged instruction buffer, redirect/drain.
// Optional FETCH_PERF_EN adds saturating perf_fetched / perf_flushed counters.
//
// state | meaning
// IDLE  | one cycle after reset before fetching starts
// RUN   | issuing requests, buffering responses
// DRAIN | discarding responses still in flight from before a redirect
module if_fetch
  import riscy_pkg::*;
#(
  parameter int                   XLEN      = riscy_pkg::XLEN,
  parameter logic [XLEN-1:0]      RESET_PC  = '0,
  parameter int                   BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  if_fetch_if.master      imem,
  input  logic            PCSrc,
  input  logic [XLEN-1:0] PCTarget,
  input  logic            dec_ready,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic [6:0]      op,
  output logic [2:0]      funct3,
  output logic            funct7
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_flushed
`endif
);

  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int SW = CW + 2;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;

  fetch_entry_t    buf_din, buf_head, pcq_din, pcq_head;
  logic            buf_push, buf_pop, buf_full, buf_empty;
  logic            pcq_push, pcq_pop, pcq_full, pcq_empty;
  logic [CW-1:0]   buf_cnt, pcq_cnt;
  logic [SW-1:0]   outstanding, credit_used, redirect_drop;
  logic            req_valid, req_hs, head_valid;

  // In RUN the PC queue holds every in-flight request; in DRAIN it is empty and drop_cnt holds them.
  assign outstanding   = SW'(pcq_cnt) + SW'(drop_cnt_q);
  assign credit_used   = outstanding + SW'(buf_cnt);
  assign redirect_drop = outstanding + SW'(req_hs) - SW'(imem.rsp_valid);

  assign req_valid = ~rst && (state_q == RUN) && ~buf_full && ~pcq_full
                     && (credit_used < SW'(BUF_DEPTH));
  assign req_hs    = req_valid & imem.req_ready;

  assign imem.req_valid = req_valid;
  assign imem.req_addr  = fetch_pc_q;

  assign pcq_din = '{pc: fetch_pc_q, instr: '0};
  assign buf_din = '{pc: pcq_head.pc, instr: imem.rsp_data};

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    drop_cnt_d = drop_cnt_q;
    buf_push   = 1'b0;
    buf_pop    = 1'b0;
    pcq_push   = 1'b0;
    pcq_pop    = 1'b0;

    if (req_hs) fetch_pc_d = fetch_pc_q + XLEN'(4);

    case (state_q)
      IDLE: state_d = RUN;
      RUN: begin
        pcq_push = req_hs;
        buf_pop  = head_valid & dec_ready;
        if (imem.rsp_valid) begin
          buf_push = 1'b1;
          pcq_pop  = 1'b1;
        end
      end
      DRAIN: begin
        if (drop_cnt_q == '0) begin
          state_d = RUN;
        end else if (imem.rsp_valid) begin
          drop_cnt_d = drop_cnt_q - 1'b1;
          if (drop_cnt_q == CW'(1)) state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase

    // Redirect overrides everything; the FIFOs see flush and ignore push/pop.
    if (PCSrc) begin
      buf_push   = 1'b0;
      buf_pop    = 1'b0;
      pcq_push   = 1'b0;
      pcq_pop    = 1'b0;
      fetch_pc_d = align_word(PCTarget);
      drop_cnt_d = CW'(redirect_drop);
      state_d    = (redirect_drop != '0) ? DRAIN : RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  fetch_fifo #(.DEPTH(BUF_DEPTH)) u_ibuf (
    .clk   (clk),
    .rst   (rst),
    .push  (buf_push),
    .pop   (buf_pop),
    .flush (PCSrc),
    .din   (buf_din),
    .dout  (buf_head),
    .full  (buf_full),
    .empty (buf_empty),
    .count (buf_cnt)
  );

  fetch_fifo #(.DEPTH(BUF_DEPTH)) u_pcq (
    .clk   (clk),
    .rst   (rst),
    .push  (pcq_push),
    .pop   (pcq_pop),
    .flush (PCSrc),
    .din   (pcq_din),
    .dout  (pcq_head),
    .full  (pcq_full),
    .empty (pcq_empty),
    .count (pcq_cnt)
  );

  assign head_valid  = ~rst & ~buf_empty;
  assign instr_valid = head_valid;
  assign instr       = head_valid ? buf_head.instr : '0;
  assign pc          = head_valid ? buf_head.pc : '0;
  assign pc_plus4    = pc + XLEN'(4);
  assign op          = instr[6:0];
  assign funct3      = instr[14:12];
  assign funct7      = instr[30];

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_fetched_d, perf_flushed_q, perf_flushed_d;

  always_comb begin
    perf_fetched_d = perf_fetched_q;
    perf_flushed_d = perf_flushed_q;
    if (PCSrc)
      perf_flushed_d = sat_add32(perf_flushed_q, 32'(buf_cnt) + 32'(pcq_cnt) + 32'(req_hs));
    else if (buf_push)
      perf_fetched_d = sat_add32(perf_fetched_q, 32'd1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched_q <= '0;
      perf_flushed_q <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_flushed_q <= perf_flushed_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_flushed = perf_flushed_q;
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: in-order memory model with 1- or 3-cycle latency, request/pop logs.
module tb_if_fetch;
  import riscy_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        PCSrc = 1'b0;
  logic [31:0] PCTarget = '0;
  logic        dec_ready = 1'b0;
  logic        mem_ready = 1'b1;
  logic [1:0]  lat_idx = 2'd0;

  logic        instr_valid;
  logic [31:0] instr, pc, pc_plus4;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_flushed;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  if_fetch_if imem ();

  if_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .imem        (imem),
    .PCSrc       (PCSrc),
    .PCTarget    (PCTarget),
    .dec_ready   (dec_ready),
    .instr_valid (instr_valid),
    .instr       (instr),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .op          (op),
    .funct3      (funct3),
    .funct7      (funct7)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_flushed(perf_flushed)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0000_2083;
    return {a[26:2], 7'b0010011};
  endfunction

  logic [3:0]  pipe_v;
  logic [31:0] pipe_d [4];

  assign imem.req_ready = mem_ready;
  assign imem.rsp_valid = pipe_v[lat_idx];
  assign imem.rsp_data  = pipe_d[lat_idx];

  always @(posedge clk) begin
    if (rst) begin
      pipe_v <= '0;
    end else begin
      pipe_v    <= {pipe_v[2:0], imem.req_valid & imem.req_ready};
      pipe_d[0] <= word(imem.req_addr);
      for (int i = 1; i < 4; i++) pipe_d[i] <= pipe_d[i-1];
    end
  end

  logic [31:0] req_log [$];
  logic [31:0] pop_pc  [$];
  logic [31:0] pop_ins [$];

  always @(negedge clk) begin
    if (!rst) begin
      if (imem.req_valid && imem.req_ready) req_log.push_back(imem.req_addr);
      if (instr_valid && dec_ready && !PCSrc) begin
        pop_pc.push_back(pc);
        pop_ins.push_back(instr);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_logs();
    req_log.delete();
    pop_pc.delete();
    pop_ins.delete();
  endtask

  task automatic start(input logic [1:0] lat, input logic dr);
    rst = 1'b1;
    PCSrc = 1'b0;
    lat_idx = lat;
    dec_ready = dr;
    mem_ready = 1'b1;
    tick(2);
    rst = 1'b0;
    clear_logs();
  endtask

  // Consumed instructions must be a gap-free PC sequence from base with matching words.
  task automatic check_seq(input string tag, input logic [31:0] base, input int n);
    int bad;
    chk({tag, "_count"}, 32'(pop_pc.size() >= n), 32'd1);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_pc"}, pop_pc[i], base + 32'(4 * i));
      chk({tag, "_ins"}, pop_ins[i], word(base + 32'(4 * i)));
    end
    bad = 0;
    for (int i = 0; i < pop_pc.size(); i++)
      if (pop_pc[i] != base + 32'(4 * i) || pop_ins[i] != word(pop_pc[i])) bad++;
    chk({tag, "_stale"}, 32'(bad), 32'd0);
  endtask

  initial begin
    logic [31:0] a_exp;
    int          got;

    // Reset state
    tick(2);
    chk("rst_req_valid", imem.req_valid, 0);
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_pc", pc, 0);
    chk("rst_pc_plus4", pc_plus4, 32'd4);
    chk("rst_op", op, 0);
    chk("rst_funct3", funct3, 0);
    chk("rst_funct7", funct7, 0);

    // 1: first fetches and minimum latency
    dec_ready = 1'b1;
    rst = 1'b0;
    clear_logs();
    tick(1);
    chk("t1_req_valid", imem.req_valid, 1);
    chk("t1_req_addr0", imem.req_addr, 32'h0);
    tick(1);
    chk("t1_not_yet_valid", instr_valid, 0);
    tick(1);
    chk("t1_instr_valid", instr_valid, 1);
    chk("t1_pc", pc, 32'h0);
    chk("t1_pc_plus4", pc_plus4, 32'h4);
    chk("t1_instr", instr, 32'h0000_2083);
    chk("t1_op", op, OP_LOAD);
    chk("t1_funct3", funct3, 3'b010);
    chk("t1_funct7", funct7, 0);
    tick(12);
    chk("t1_req0", req_log[0], 32'h0);
    chk("t1_req1", req_log[1], 32'h4);
    chk("t1_req2", req_log[2], 32'h8);
    check_seq("t1_seq", 32'h0, 3);

    // 2: stalled consumer limits issue to BUF_DEPTH
    start(2'd0, 1'b0);
    tick(8);
    chk("t2_req_count", 32'(req_log.size()), 32'd2);
    chk("t2_req_valid_low", imem.req_valid, 0);
    chk("t2_head_valid", instr_valid, 1);
    chk("t2_head_pc", pc, 32'h0);
    dec_ready = 1'b1;
    tick(14);
    check_seq("t2_seq", 32'h0, 5);

    // 3: redirect with two requests outstanding (3-cycle memory)
    start(2'd2, 1'b1);
    tick(3);
    chk("t3_two_issued", 32'(req_log.size()), 32'd2);
    chk("t3_no_rsp_yet", imem.rsp_valid, 0);
    PCSrc = 1'b1;
    PCTarget = 32'h0000_0101;
    tick(1);
    PCSrc = 1'b0;
    clear_logs();
    chk("t3_state", dut.state_q, DRAIN);
    chk("t3_drop_cnt", 32'(dut.drop_cnt_q), 32'd2);
    chk("t3_req_off", imem.req_valid, 0);
    tick(1);
    chk("t3_still_draining", imem.req_valid, 0);
    tick(1);
    chk("t3_req_resume", imem.req_valid, 1);
    chk("t3_req_addr", imem.req_addr, 32'h100);
    tick(14);
    chk("t3_first_req", req_log[0], 32'h100);
    check_seq("t3_seq", 32'h100, 3);

    // 4: redirect coinciding with a response and a request handshake
    start(2'd0, 1'b1);
    tick(2);
    chk("t4_rsp_same_cycle", imem.rsp_valid, 1);
    chk("t4_req_same_cycle", imem.req_valid, 1);
    PCSrc = 1'b1;
    PCTarget = 32'h0000_0200;
    tick(1);
    PCSrc = 1'b0;
    clear_logs();
    chk("t4_state", dut.state_q, DRAIN);
    chk("t4_drop_cnt", 32'(dut.drop_cnt_q), 32'd1);
    chk("t4_instr_valid", instr_valid, 0);
    tick(1);
    chk("t4_req_valid", imem.req_valid, 1);
    chk("t4_req_addr", imem.req_addr, 32'h200);
    tick(14);
    check_seq("t4_seq", 32'h200, 4);

    // 5: memory not ready holds the address; reset mid-wait
    mem_ready = 1'b0;
    got = 0;
    for (int i = 0; i < 8 && got == 0; i++) begin
      tick(1);
      if (imem.req_valid) got = 1;
    end
    chk("t5_req_pending", 32'(got), 32'd1);
    a_exp = req_log[$] + 32'd4;
    for (int i = 0; i < 4; i++) begin
      chk("t5_hold_valid", imem.req_valid, 1);
      chk("t5_hold_addr", imem.req_addr, a_exp);
      tick(1);
    end
    rst = 1'b1;
    tick(1);
    chk("t5_rst_req_valid", imem.req_valid, 0);
    chk("t5_rst_instr_valid", instr_valid, 0);
    chk("t5_rst_pc", pc, 0);
    rst = 1'b0;
    mem_ready = 1'b1;
    tick(1);
    chk("t5_req_valid", imem.req_valid, 1);
    chk("t5_req_addr", imem.req_addr, 32'h0);
    tick(1);
    chk("t5_instr_valid", instr_valid, 0);

`ifdef FETCH_PERF_EN
    // 6: performance counters
    start(2'd0, 1'b0);
    tick(6);
    chk("t6_fetched_fill", perf_fetched, 32'd2);
    for (int i = 0; i < 8; i++) begin
      dec_ready = 1'b1;
      tick(1);
      dec_ready = 1'b0;
      tick(3);
    end
    chk("t6_fetched_10", perf_fetched, 32'd10);
    chk("t6_flushed_0", perf_flushed, 32'd0);
    PCSrc = 1'b1;
    PCTarget = 32'h0000_0300;
    tick(1);
    PCSrc = 1'b0;
    chk("t6_flushed_2", perf_flushed, 32'd2);
    chk("t6_req_addr", imem.req_addr, 32'h300);
    tick(1);
    mem_ready = 1'b0;
    PCSrc = 1'b1;
    PCTarget = 32'h0000_0400;
    tick(1);
    PCSrc = 1'b0;
    tick(2);
    chk("t6_fetched_final", perf_fetched, 32'd10);
    chk("t6_flushed_final", perf_flushed, 32'd3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
